mem_stage_unit: RTL and testbench
=================================

# mem_stage_unit

MEM-stage data-memory unit of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its memory controls, ALU result (address), Register2 read data (store data) and branch/zero flags. It performs word/half/byte loads and stores against an internal data memory with a fixed multi-cycle access latency, stalls the pipeline while an access is in flight, and resolves the branch decision. Its read data feeds the MEM/WB register.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit memory words; power of two.
- LATENCY, 2: access latency in cycles; must be at least 1.

- Clk  in  1  pipeline clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- MemReadIn  in  1  load request (from Ctrl_Mem).
- MemWriteIn  in  1  store request (from Ctrl_Mem).
- BranchIn  in  1  branch instruction flag (from Ctrl_Mem).
- ALU_ZeroIn  in  1  ALU zero flag.
- SizeIn  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- SignedIn  in  1  1 = sign-extend half/byte loads, 0 = zero-extend.
- AddressIn  in  32  byte address (ALU result).
- WriteDataIn  in  32  store data; half/byte use low bits.
- ReadDataOut  out  32  load result, registered.
- PCSrcOut  out  1  branch taken = BranchIn & ALU_ZeroIn, combinational.
- StallOut  out  1  hold upstream stages and EX/MEM register, combinational.
- MisalignOut  out  1  misaligned access flagged this cycle, combinational.

## Operation
- States: IDLE, BUSY, DONE. Internal down-counter sized for LATENCY-1.
- Request = (MemReadIn | MemWriteIn) & aligned.
- Alignment: word needs AddressIn[1:0]=00; half needs AddressIn[0]=0; byte always aligned.
- IDLE: no request -> StallOut=0, stay. Request -> StallOut=1, counter <= LATENCY-1, go BUSY. Misaligned with MemRead or MemWrite -> MisalignOut=1, StallOut=0, no access, no write, stay IDLE.
- BUSY: StallOut=1. If counter != 0, decrement. If counter == 0: perform access at this edge (store commits to memory; load result latched into ReadDataOut), go DONE.
- DONE: StallOut=0, ReadDataOut valid; go IDLE unconditionally. Inputs in DONE are not evaluated as a new request.
- Word index = AddressIn[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (address wraps).
- Byte lanes little-endian: byte 0 = bits 7:0. Half 0 = bits 15:0, half 1 = bits 31:16 (select by AddressIn[1]).
- Stores: byte/half write only the addressed lane(s); other lanes unchanged.
- Loads: selected lane right-justified, then sign- or zero-extended per SignedIn; word loads ignore SignedIn.
- MemReadIn and MemWriteIn both high: store only; ReadDataOut unchanged.
- ReadDataOut holds its value except on a load completion or reset.
- PCSrcOut independent of state, stall and memory request.

## Timing
- Reset (priority over everything): state IDLE, counter 0, ReadDataOut 0. StallOut=0 and MisalignOut=0 while Rst high. Memory contents not reset.
- Reset mid-access (in BUSY): access aborted, pending store not committed, ReadDataOut 0.
- Request presented in cycle T0: StallOut high T0..T0+LATENCY (LATENCY+1 cycles). Access at the edge ending T0+LATENCY. DONE in T0+LATENCY+1 with StallOut low, so MEM/WB captures ReadDataOut at the end of that cycle.
- Inputs required stable from T0 through the access edge; guaranteed by the upstream hold under StallOut.
- Back-to-back accesses: minimum spacing LATENCY+2 cycles (DONE always costs one cycle).
- Non-memory instructions pass with zero stall; MisalignOut and PCSrcOut are valid in the same cycle.

## Test plan
- Reset then idle: Rst=1 two cycles -> ReadDataOut=0, StallOut=0; MemRead=MemWrite=0 -> StallOut stays 0.
- Word store/load, LATENCY=2: store 0xDEADBEEF @0x10 -> StallOut high 3 cycles, then DONE; load word @0x10 -> ReadDataOut=0xDEADBEEF in DONE cycle.
- Byte/half with extension: store byte 0x80 @0x21 over word 0 -> load word @0x20 = 0x00008000; load byte signed @0x21 = 0xFFFFFF80; unsigned = 0x00000080; store half 0xFFFE @0x22, load half signed = 0xFFFFFFFE.
- Misalignment: load word @0x13 -> MisalignOut=1 same cycle, StallOut=0, ReadDataOut unchanged; store half @0x31 -> no memory change (verify by aligned reload).
- Reset mid-access: store 0x12345678 @0x40, assert Rst in first BUSY cycle -> later load @0x40 returns prior contents; ReadDataOut=0 after reset.
- Branch and wrap: BranchIn=1, ALU_ZeroIn=1 -> PCSrcOut=1 with StallOut=0; with DEPTH_WORDS=1024, store @0x1000 then load @0x0 -> same data.

Source files
------------

// File: rtl/mem_stage_unit.sv
// mem_stage_unit
// MEM-stage data memory for the 5-stage MIPS pipeline. Performs word/half/byte
// loads and stores against an internal memory with a fixed access latency,
// stalls upstream while an access is in flight, and resolves the branch.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   MemReadIn/WriteIn   load / store request
//   BranchIn, ALU_ZeroIn branch flag and ALU zero -> PCSrcOut
//   SizeIn, SignedIn    access size (00 word, 01 half, 10 byte, 11 word), load extension
//   AddressIn           byte address; bits above the word index are ignored
//   WriteDataIn         store data (half/byte use the low bits)
//   ReadDataOut         registered load result, updated only on load completion
//   StallOut            hold upstream stages while an access is pending
//   MisalignOut         misaligned request this cycle (access dropped)
//
// state | meaning
// IDLE  | waiting; a new aligned request starts an access
// BUSY  | access in flight; counter runs down, access at the edge with counter 0
// DONE  | one-cycle result slot, stall released, inputs ignored
module mem_stage_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        BranchIn,
  input  logic        ALU_ZeroIn,
  input  logic [1:0]  SizeIn,
  input  logic        SignedIn,
  input  logic [31:0] AddressIn,
  input  logic [31:0] WriteDataIn,
  output logic [31:0] ReadDataOut,
  output logic        PCSrcOut,
  output logic        StallOut,
  output logic        MisalignOut
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            mem_op;
  logic            aligned;
  logic            start;
  logic            access_fire;
  logic [AW-1:0]   idx;
  logic [31:0]     cur_word;
  logic [31:0]     store_word;
  logic [31:0]     load_word;
  logic [15:0]     half_sel;
  logic [7:0]      byte_sel;
  logic            unused_addr_hi;

  assign idx            = AddressIn[AW+1:2];
  assign unused_addr_hi = ^AddressIn[31:AW+2];
  assign cur_word       = mem[idx];
  assign mem_op         = MemReadIn | MemWriteIn;
  assign PCSrcOut       = BranchIn & ALU_ZeroIn;

  always_comb begin
    aligned = 1'b1;
    case (SizeIn)
      2'b01:   aligned = ~AddressIn[0];
      2'b10:   aligned = 1'b1;
      default: aligned = (AddressIn[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    next_state  = state;
    StallOut    = 1'b0;
    MisalignOut = 1'b0;
    start       = 1'b0;
    access_fire = 1'b0;
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (mem_op && aligned) begin
            StallOut   = 1'b1;
            start      = 1'b1;
            next_state = BUSY;
          end else if (mem_op) begin
            MisalignOut = 1'b1;
          end
        end
        BUSY: begin
          StallOut = 1'b1;
          if (cnt == '0) begin
            access_fire = 1'b1;
            next_state  = DONE;
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge Clk) begin
    if (Rst)                     cnt <= '0;
    else if (start)              cnt <= CW'(LATENCY - 1);
    else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
  end

  // Sub-word stores are read-modify-write on the whole word so untouched
  // lanes keep their contents.
  always_comb begin
    store_word = WriteDataIn;
    case (SizeIn)
      2'b01: begin
        if (AddressIn[1]) store_word = {WriteDataIn[15:0], cur_word[15:0]};
        else              store_word = {cur_word[31:16], WriteDataIn[15:0]};
      end
      2'b10: begin
        case (AddressIn[1:0])
          2'b00:   store_word = {cur_word[31:8], WriteDataIn[7:0]};
          2'b01:   store_word = {cur_word[31:16], WriteDataIn[7:0], cur_word[7:0]};
          2'b10:   store_word = {cur_word[31:24], WriteDataIn[7:0], cur_word[15:0]};
          default: store_word = {WriteDataIn[7:0], cur_word[23:0]};
        endcase
      end
      default: store_word = WriteDataIn;
    endcase
  end

  always_comb begin
    half_sel = AddressIn[1] ? cur_word[31:16] : cur_word[15:0];
    case (AddressIn[1:0])
      2'b00:   byte_sel = cur_word[7:0];
      2'b01:   byte_sel = cur_word[15:8];
      2'b10:   byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase
    case (SizeIn)
      2'b01:   load_word = SignedIn ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      2'b10:   load_word = SignedIn ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      default: load_word = cur_word;
    endcase
  end

  // Memory contents survive reset; access_fire is already masked by Rst.
  always_ff @(posedge Clk) begin
    if (access_fire && MemWriteIn) mem[idx] <= store_word;
  end

  // Read and write together is a store; the load side is suppressed.
  always_ff @(posedge Clk) begin
    if (Rst)                                     ReadDataOut <= '0;
    else if (access_fire && MemReadIn && !MemWriteIn) ReadDataOut <= load_word;
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemReadIn, MemWriteIn, BranchIn, ALU_ZeroIn, SignedIn;
  logic [1:0]  SizeIn;
  logic [31:0] AddressIn, WriteDataIn;
  logic [31:0] ReadDataOut;
  logic        PCSrcOut, StallOut, MisalignOut;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem_stage_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .BranchIn(BranchIn), .ALU_ZeroIn(ALU_ZeroIn),
    .SizeIn(SizeIn), .SignedIn(SignedIn),
    .AddressIn(AddressIn), .WriteDataIn(WriteDataIn),
    .ReadDataOut(ReadDataOut), .PCSrcOut(PCSrcOut),
    .StallOut(StallOut), .MisalignOut(MisalignOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request right after a rising edge and counts stalled cycles.
  // Returns at the falling edge of the first non-stalled cycle (DONE, or the
  // same cycle for a dropped/non-memory request).
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls);
    @(posedge Clk); #1;
    MemReadIn = rd; MemWriteIn = wr; SizeIn = sz; SignedIn = sg;
    AddressIn = addr; WriteDataIn = wd;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!StallOut) break;
      stalls++;
      if (i == 19) begin
        checks++; failures++;
        $display("FAIL stall_timeout observed=stuck expected=release");
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge Clk); #1;
    MemReadIn = 0; MemWriteIn = 0;
  endtask

  int st;

  initial begin
    Rst = 1; MemReadIn = 0; MemWriteIn = 0; BranchIn = 0; ALU_ZeroIn = 0;
    SizeIn = 2'b00; SignedIn = 0; AddressIn = 0; WriteDataIn = 0;

    // reset, with a request driven to confirm reset masks the outputs
    @(posedge Clk); #1;
    MemReadIn = 1; AddressIn = 32'h13;
    @(posedge Clk);
    @(negedge Clk);
    check("rst_rdata", ReadDataOut, 32'h0);
    check("rst_stall", {31'b0, StallOut}, 32'h0);
    check("rst_misalign", {31'b0, MisalignOut}, 32'h0);
    #1; Rst = 0; MemReadIn = 0; AddressIn = 0;
    @(negedge Clk);
    check("idle_stall", {31'b0, StallOut}, 32'h0);

    // word store / load
    access(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, st);
    check("sw_stall_cycles", st, 3);
    check("sw_rdata_kept", ReadDataOut, 32'h0);
    access(1, 0, 2'b00, 0, 32'h10, 32'h0, st);
    check("lw_stall_cycles", st, 3);
    check("lw_data", ReadDataOut, 32'hDEADBEEF);

    // byte / half with extension
    access(0, 1, 2'b00, 0, 32'h20, 32'h0, st);
    access(0, 1, 2'b10, 0, 32'h21, 32'hFFFFFF80, st);
    access(1, 0, 2'b00, 0, 32'h20, 32'h0, st);
    check("sb_then_lw", ReadDataOut, 32'h00008000);
    access(1, 0, 2'b10, 1, 32'h21, 32'h0, st);
    check("lb_signed", ReadDataOut, 32'hFFFFFF80);
    access(1, 0, 2'b10, 0, 32'h21, 32'h0, st);
    check("lbu", ReadDataOut, 32'h00000080);
    access(0, 1, 2'b01, 0, 32'h22, 32'h1234FFFE, st);
    access(1, 0, 2'b01, 1, 32'h22, 32'h0, st);
    check("lh_signed", ReadDataOut, 32'hFFFFFFFE);
    access(1, 0, 2'b01, 0, 32'h20, 32'h0, st);
    check("lhu_low", ReadDataOut, 32'h00008000);
    access(1, 0, 2'b00, 0, 32'h20, 32'h0, st);
    check("sh_lanes", ReadDataOut, 32'hFFFE8000);
    access(1, 0, 2'b10, 0, 32'h23, 32'h0, st);
    check("lbu_lane3", ReadDataOut, 32'h000000FF);

    // misalignment
    access(1, 0, 2'b00, 0, 32'h13, 32'h0, st);
    check("mis_lw_flag", {31'b0, MisalignOut}, 32'h1);
    check("mis_lw_stall", st, 0);
    check("mis_lw_rdata", ReadDataOut, 32'h000000FF);
    go_idle();
    access(0, 1, 2'b00, 0, 32'h30, 32'h11111111, st);
    access(0, 1, 2'b01, 0, 32'h31, 32'h0000ABCD, st);
    check("mis_sh_flag", {31'b0, MisalignOut}, 32'h1);
    go_idle();
    access(1, 0, 2'b00, 0, 32'h30, 32'h0, st);
    check("mis_sh_nowrite", ReadDataOut, 32'h11111111);

    // read and write together: store only
    access(1, 1, 2'b00, 0, 32'h50, 32'h00000055, st);
    check("rw_stall_cycles", st, 3);
    check("rw_rdata_kept", ReadDataOut, 32'h11111111);
    access(1, 0, 2'b00, 0, 32'h50, 32'h0, st);
    check("rw_stored", ReadDataOut, 32'h00000055);

    // reset during the first BUSY cycle aborts the store
    access(0, 1, 2'b00, 0, 32'h40, 32'hCAFEF00D, st);
    @(posedge Clk); #1;
    MemReadIn = 0; MemWriteIn = 1; SizeIn = 2'b00; AddressIn = 32'h40; WriteDataIn = 32'h12345678;
    @(posedge Clk); #1;
    Rst = 1;
    @(posedge Clk); #1;
    Rst = 0; MemWriteIn = 0;
    @(negedge Clk);
    check("midrst_rdata", ReadDataOut, 32'h0);
    check("midrst_stall", {31'b0, StallOut}, 32'h0);
    access(1, 0, 2'b00, 0, 32'h40, 32'h0, st);
    check("midrst_nocommit", ReadDataOut, 32'hCAFEF00D);

    // branch resolution, non-memory pass-through
    go_idle();
    BranchIn = 1; ALU_ZeroIn = 1;
    @(negedge Clk);
    check("br_taken", {31'b0, PCSrcOut}, 32'h1);
    check("br_nostall", {31'b0, StallOut}, 32'h0);
    ALU_ZeroIn = 0;
    #1;
    check("br_not_taken", {31'b0, PCSrcOut}, 32'h0);
    BranchIn = 0;

    // address wrap
    access(0, 1, 2'b00, 0, 32'h1000, 32'h0BADC0DE, st);
    access(1, 0, 2'b00, 0, 32'h0, 32'h0, st);
    check("wrap", ReadDataOut, 32'h0BADC0DE);

    go_idle();
    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
